// File: rtl/tl_buffer_ad_if.sv
// TileLink port bundle (channels A-E) for the tl_buffer_ad stage.
// master drives A/C/E and the B/D readys; slave is the mirror image.
interface tl_buffer_ad_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_bits_opcode;
  logic [2:0]  a_bits_param;
  logic [3:0]  a_bits_size;
  logic [3:0]  a_bits_source;
  logic [31:0] a_bits_address;
  logic [7:0]  a_bits_mask;
  logic [63:0] a_bits_data;
  logic        a_bits_corrupt;

  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_bits_param;
  logic [3:0]  b_bits_source;
  logic [31:0] b_bits_address;

  logic        c_valid;
  logic        c_ready;
  logic [2:0]  c_bits_opcode;
  logic [2:0]  c_bits_param;
  logic [3:0]  c_bits_size;
  logic [3:0]  c_bits_source;
  logic [31:0] c_bits_address;
  logic [63:0] c_bits_data;
  logic        c_bits_corrupt;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_bits_opcode;
  logic [1:0]  d_bits_param;
  logic [3:0]  d_bits_size;
  logic [3:0]  d_bits_source;
  logic [2:0]  d_bits_sink;
  logic        d_bits_denied;
  logic [63:0] d_bits_data;
  logic        d_bits_corrupt;

  logic        e_valid;
  logic        e_ready;
  logic [2:0]  e_bits_sink;

  modport master (
    output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source, a_bits_address,
           a_bits_mask, a_bits_data, a_bits_corrupt,
    input  a_ready,
    input  b_valid, b_bits_param, b_bits_source, b_bits_address,
    output b_ready,
    output c_valid, c_bits_opcode, c_bits_param, c_bits_size, c_bits_source, c_bits_address,
           c_bits_data, c_bits_corrupt,
    input  c_ready,
    input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source, d_bits_sink,
           d_bits_denied, d_bits_data, d_bits_corrupt,
    output d_ready,
    output e_valid, e_bits_sink,
    input  e_ready
  );

  modport slave (
    input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source, a_bits_address,
           a_bits_mask, a_bits_data, a_bits_corrupt,
    output a_ready,
    output b_valid, b_bits_param, b_bits_source, b_bits_address,
    input  b_ready,
    input  c_valid, c_bits_opcode, c_bits_param, c_bits_size, c_bits_source, c_bits_address,
           c_bits_data, c_bits_corrupt,
    output c_ready,
    output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source, d_bits_sink,
           d_bits_denied, d_bits_data, d_bits_corrupt,
    input  d_ready,
    input  e_valid, e_bits_sink,
    output e_ready
  );
endinterface

// File: rtl/tl_buffer_ad.sv
// Registered TileLink buffer: circular FIFOs on channels A and D, no bypass or flow-through.
// Define TL_BUFFER_BCE_EN to also give B, C and E a 2-entry FIFO; otherwise they pass through.
module tl_buffer_ad #(
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2
) (
  input logic            clock,
  input logic            reset,
  tl_buffer_ad_if.slave  auto_in,
  tl_buffer_ad_if.master auto_out
);

  localparam int unsigned AW   = $clog2(A_DEPTH);
  localparam int unsigned DW   = $clog2(D_DEPTH);
  localparam int unsigned AWID = 119;
  localparam int unsigned DWID = 82;

  // ---------------------------------------------------------------- channel A
  logic [AWID-1:0] a_mem [A_DEPTH];
  logic [AWID-1:0] a_wdata, a_rdata;
  logic [AW-1:0]   a_wptr_q, a_wptr_d, a_rptr_q, a_rptr_d;
  logic            a_mfull_q, a_mfull_d;
  logic            a_empty, a_full, a_enq, a_deq;

  assign a_wdata = {auto_in.a_bits_opcode, auto_in.a_bits_param, auto_in.a_bits_size,
                    auto_in.a_bits_source, auto_in.a_bits_address, auto_in.a_bits_mask,
                    auto_in.a_bits_data, auto_in.a_bits_corrupt};
  assign a_rdata = a_mem[a_rptr_q];
  assign {auto_out.a_bits_opcode, auto_out.a_bits_param, auto_out.a_bits_size,
          auto_out.a_bits_source, auto_out.a_bits_address, auto_out.a_bits_mask,
          auto_out.a_bits_data, auto_out.a_bits_corrupt} = a_rdata;

  assign a_empty         = (a_wptr_q == a_rptr_q) & ~a_mfull_q;
  assign a_full          = (a_wptr_q == a_rptr_q) &  a_mfull_q;
  assign auto_in.a_ready = ~a_full;
  assign auto_out.a_valid = ~a_empty;
  assign a_enq = auto_in.a_valid & ~a_full;
  assign a_deq = auto_out.a_ready & ~a_empty;

  always_comb begin
    a_wptr_d  = a_wptr_q;
    a_rptr_d  = a_rptr_q;
    a_mfull_d = a_mfull_q;
    if (a_enq) a_wptr_d = a_wptr_q + AW'(1);
    if (a_deq) a_rptr_d = a_rptr_q + AW'(1);
    if (a_enq != a_deq) a_mfull_d = a_enq;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_wptr_q  <= '0;
      a_rptr_q  <= '0;
      a_mfull_q <= 1'b0;
    end else begin
      a_wptr_q  <= a_wptr_d;
      a_rptr_q  <= a_rptr_d;
      a_mfull_q <= a_mfull_d;
    end
  end

  // Payload storage is intentionally left unreset.
  always_ff @(posedge clock) begin
    if (a_enq) a_mem[a_wptr_q] <= a_wdata;
  end

  // ---------------------------------------------------------------- channel D
  logic [DWID-1:0] d_mem [D_DEPTH];
  logic [DWID-1:0] d_wdata, d_rdata;
  logic [DW-1:0]   d_wptr_q, d_wptr_d, d_rptr_q, d_rptr_d;
  logic            d_mfull_q, d_mfull_d;
  logic            d_empty, d_full, d_enq, d_deq;

  assign d_wdata = {auto_out.d_bits_opcode, auto_out.d_bits_param, auto_out.d_bits_size,
                    auto_out.d_bits_source, auto_out.d_bits_sink, auto_out.d_bits_denied,
                    auto_out.d_bits_data, auto_out.d_bits_corrupt};
  assign d_rdata = d_mem[d_rptr_q];
  assign {auto_in.d_bits_opcode, auto_in.d_bits_param, auto_in.d_bits_size,
          auto_in.d_bits_source, auto_in.d_bits_sink, auto_in.d_bits_denied,
          auto_in.d_bits_data, auto_in.d_bits_corrupt} = d_rdata;

  assign d_empty          = (d_wptr_q == d_rptr_q) & ~d_mfull_q;
  assign d_full           = (d_wptr_q == d_rptr_q) &  d_mfull_q;
  assign auto_out.d_ready = ~d_full;
  assign auto_in.d_valid  = ~d_empty;
  assign d_enq = auto_out.d_valid & ~d_full;
  assign d_deq = auto_in.d_ready & ~d_empty;

  always_comb begin
    d_wptr_d  = d_wptr_q;
    d_rptr_d  = d_rptr_q;
    d_mfull_d = d_mfull_q;
    if (d_enq) d_wptr_d = d_wptr_q + DW'(1);
    if (d_deq) d_rptr_d = d_rptr_q + DW'(1);
    if (d_enq != d_deq) d_mfull_d = d_enq;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_wptr_q  <= '0;
      d_rptr_q  <= '0;
      d_mfull_q <= 1'b0;
    end else begin
      d_wptr_q  <= d_wptr_d;
      d_rptr_q  <= d_rptr_d;
      d_mfull_q <= d_mfull_d;
    end
  end

  always_ff @(posedge clock) begin
    if (d_enq) d_mem[d_wptr_q] <= d_wdata;
  end

`ifdef TL_BUFFER_BCE_EN
  // ------------------------------------------------- channels B, C, E (2-entry)
  logic [37:0]  b_mem [2];
  logic [110:0] c_mem [2];
  logic [2:0]   e_mem [2];
  logic         b_wptr_q, b_rptr_q, b_mfull_q, b_wptr_d, b_rptr_d, b_mfull_d;
  logic         c_wptr_q, c_rptr_q, c_mfull_q, c_wptr_d, c_rptr_d, c_mfull_d;
  logic         e_wptr_q, e_rptr_q, e_mfull_q, e_wptr_d, e_rptr_d, e_mfull_d;
  logic         b_empty, b_full, b_enq, b_deq;
  logic         c_empty, c_full, c_enq, c_deq;
  logic         e_empty, e_full, e_enq, e_deq;

  assign b_empty = (b_wptr_q == b_rptr_q) & ~b_mfull_q;
  assign b_full  = (b_wptr_q == b_rptr_q) &  b_mfull_q;
  assign c_empty = (c_wptr_q == c_rptr_q) & ~c_mfull_q;
  assign c_full  = (c_wptr_q == c_rptr_q) &  c_mfull_q;
  assign e_empty = (e_wptr_q == e_rptr_q) & ~e_mfull_q;
  assign e_full  = (e_wptr_q == e_rptr_q) &  e_mfull_q;

  assign auto_out.b_ready = ~b_full;
  assign auto_in.b_valid  = ~b_empty;
  assign auto_in.c_ready  = ~c_full;
  assign auto_out.c_valid = ~c_empty;
  assign auto_in.e_ready  = ~e_full;
  assign auto_out.e_valid = ~e_empty;

  assign b_enq = auto_out.b_valid & ~b_full;
  assign b_deq = auto_in.b_ready & ~b_empty;
  assign c_enq = auto_in.c_valid & ~c_full;
  assign c_deq = auto_out.c_ready & ~c_empty;
  assign e_enq = auto_in.e_valid & ~e_full;
  assign e_deq = auto_out.e_ready & ~e_empty;

  assign {auto_in.b_bits_param, auto_in.b_bits_source, auto_in.b_bits_address} = b_mem[b_rptr_q];
  assign {auto_out.c_bits_opcode, auto_out.c_bits_param, auto_out.c_bits_size,
          auto_out.c_bits_source, auto_out.c_bits_address, auto_out.c_bits_data,
          auto_out.c_bits_corrupt} = c_mem[c_rptr_q];
  assign auto_out.e_bits_sink = e_mem[e_rptr_q];

  always_comb begin
    b_wptr_d  = b_wptr_q ^ b_enq;
    b_rptr_d  = b_rptr_q ^ b_deq;
    b_mfull_d = (b_enq != b_deq) ? b_enq : b_mfull_q;
    c_wptr_d  = c_wptr_q ^ c_enq;
    c_rptr_d  = c_rptr_q ^ c_deq;
    c_mfull_d = (c_enq != c_deq) ? c_enq : c_mfull_q;
    e_wptr_d  = e_wptr_q ^ e_enq;
    e_rptr_d  = e_rptr_q ^ e_deq;
    e_mfull_d = (e_enq != e_deq) ? e_enq : e_mfull_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {b_wptr_q, b_rptr_q, b_mfull_q} <= 3'b000;
      {c_wptr_q, c_rptr_q, c_mfull_q} <= 3'b000;
      {e_wptr_q, e_rptr_q, e_mfull_q} <= 3'b000;
    end else begin
      {b_wptr_q, b_rptr_q, b_mfull_q} <= {b_wptr_d, b_rptr_d, b_mfull_d};
      {c_wptr_q, c_rptr_q, c_mfull_q} <= {c_wptr_d, c_rptr_d, c_mfull_d};
      {e_wptr_q, e_rptr_q, e_mfull_q} <= {e_wptr_d, e_rptr_d, e_mfull_d};
    end
  end

  always_ff @(posedge clock) begin
    if (b_enq) b_mem[b_wptr_q] <= {auto_out.b_bits_param, auto_out.b_bits_source,
                                   auto_out.b_bits_address};
    if (c_enq) c_mem[c_wptr_q] <= {auto_in.c_bits_opcode, auto_in.c_bits_param,
                                   auto_in.c_bits_size, auto_in.c_bits_source,
                                   auto_in.c_bits_address, auto_in.c_bits_data,
                                   auto_in.c_bits_corrupt};
    if (e_enq) e_mem[e_wptr_q] <= auto_in.e_bits_sink;
  end
`else
  // ------------------------------------------------- channels B, C, E (wires)
  assign auto_in.b_valid        = auto_out.b_valid;
  assign auto_in.b_bits_param   = auto_out.b_bits_param;
  assign auto_in.b_bits_source  = auto_out.b_bits_source;
  assign auto_in.b_bits_address = auto_out.b_bits_address;
  assign auto_out.b_ready       = auto_in.b_ready;

  assign auto_out.c_valid        = auto_in.c_valid;
  assign auto_out.c_bits_opcode  = auto_in.c_bits_opcode;
  assign auto_out.c_bits_param   = auto_in.c_bits_param;
  assign auto_out.c_bits_size    = auto_in.c_bits_size;
  assign auto_out.c_bits_source  = auto_in.c_bits_source;
  assign auto_out.c_bits_address = auto_in.c_bits_address;
  assign auto_out.c_bits_data    = auto_in.c_bits_data;
  assign auto_out.c_bits_corrupt = auto_in.c_bits_corrupt;
  assign auto_in.c_ready         = auto_out.c_ready;

  assign auto_out.e_valid     = auto_in.e_valid;
  assign auto_out.e_bits_sink = auto_in.e_bits_sink;
  assign auto_in.e_ready      = auto_out.e_ready;
`endif

endmodule

// File: tb/tb_tl_buffer_ad.sv
// Randomised self-checking bench for tl_buffer_ad; channels A and D are checked against
// queue models of an N-entry registered FIFO (no bypass, no flow-through).
module tb_tl_buffer_ad;
  localparam int unsigned A_DEPTH = 2;
  localparam int unsigned D_DEPTH = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tl_buffer_ad_if bus_in ();
  tl_buffer_ad_if bus_out ();

  tl_buffer_ad #(
    .A_DEPTH (A_DEPTH),
    .D_DEPTH (D_DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .auto_in  (bus_in),
    .auto_out (bus_out)
  );

  logic [118:0] a_drv;
  logic [81:0]  d_drv;
  logic [37:0]  b_drv;
  logic [110:0] c_drv;
  logic [2:0]   e_drv;
  wire  [118:0] a_obs;
  wire  [81:0]  d_obs;
  wire  [37:0]  b_obs;
  wire  [110:0] c_obs;
  wire  [2:0]   e_obs;

  assign {bus_in.a_bits_opcode, bus_in.a_bits_param, bus_in.a_bits_size, bus_in.a_bits_source,
          bus_in.a_bits_address, bus_in.a_bits_mask, bus_in.a_bits_data,
          bus_in.a_bits_corrupt} = a_drv;
  assign a_obs = {bus_out.a_bits_opcode, bus_out.a_bits_param, bus_out.a_bits_size,
                  bus_out.a_bits_source, bus_out.a_bits_address, bus_out.a_bits_mask,
                  bus_out.a_bits_data, bus_out.a_bits_corrupt};
  assign {bus_out.d_bits_opcode, bus_out.d_bits_param, bus_out.d_bits_size,
          bus_out.d_bits_source, bus_out.d_bits_sink, bus_out.d_bits_denied,
          bus_out.d_bits_data, bus_out.d_bits_corrupt} = d_drv;
  assign d_obs = {bus_in.d_bits_opcode, bus_in.d_bits_param, bus_in.d_bits_size,
                  bus_in.d_bits_source, bus_in.d_bits_sink, bus_in.d_bits_denied,
                  bus_in.d_bits_data, bus_in.d_bits_corrupt};
  assign {bus_out.b_bits_param, bus_out.b_bits_source, bus_out.b_bits_address} = b_drv;
  assign b_obs = {bus_in.b_bits_param, bus_in.b_bits_source, bus_in.b_bits_address};
  assign {bus_in.c_bits_opcode, bus_in.c_bits_param, bus_in.c_bits_size, bus_in.c_bits_source,
          bus_in.c_bits_address, bus_in.c_bits_data, bus_in.c_bits_corrupt} = c_drv;
  assign c_obs = {bus_out.c_bits_opcode, bus_out.c_bits_param, bus_out.c_bits_size,
                  bus_out.c_bits_source, bus_out.c_bits_address, bus_out.c_bits_data,
                  bus_out.c_bits_corrupt};
  assign bus_in.e_bits_sink = e_drv;
  assign e_obs = bus_out.e_bits_sink;

  int unsigned  n_compared   = 0;
  int unsigned  n_mismatched = 0;
  logic [118:0] qa [$];
  logic [81:0]  qd [$];
  int unsigned  a_out_cnt = 0;
  int unsigned  d_out_cnt = 0;
  bit           last_a_enq;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entered just after a rising edge; checks at the falling edge, then advances the model.
  task automatic cycle();
    bit ev_a, er_a, ev_d, er_d, enq_a, deq_a, enq_d, deq_d;
    @(negedge clock);
    ev_a = (qa.size() != 0);
    er_a = (qa.size() < A_DEPTH);
    ev_d = (qd.size() != 0);
    er_d = (qd.size() < D_DEPTH);
    check_eq("out_a_valid", bus_out.a_valid, ev_a);
    check_eq("in_a_ready", bus_in.a_ready, er_a);
    if (ev_a) check_eq("out_a_bits", a_obs, qa[0]);
    check_eq("in_d_valid", bus_in.d_valid, ev_d);
    check_eq("out_d_ready", bus_out.d_ready, er_d);
    if (ev_d) check_eq("in_d_bits", d_obs, qd[0]);
    enq_a = bus_in.a_valid && er_a;
    deq_a = ev_a && bus_out.a_ready;
    enq_d = bus_out.d_valid && er_d;
    deq_d = ev_d && bus_in.d_ready;
    if (deq_a) begin void'(qa.pop_front()); a_out_cnt++; end
    if (enq_a) qa.push_back(a_drv);
    if (deq_d) begin void'(qd.pop_front()); d_out_cnt++; end
    if (enq_d) qd.push_back(d_drv);
    last_a_enq = enq_a;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus_in.a_valid  = 1'b0;  bus_out.a_ready = 1'b1;
    bus_out.d_valid = 1'b0;  bus_in.d_ready  = 1'b1;
    bus_out.b_valid = 1'b0;  bus_in.b_ready  = 1'b1;
    bus_in.c_valid  = 1'b0;  bus_out.c_ready = 1'b1;
    bus_in.e_valid  = 1'b0;  bus_out.e_ready = 1'b1;
  endtask

  initial begin
    logic [118:0] get_beat;
    logic [127:0] r;
    int unsigned  base;
    bit           accepted;

    idle();
    a_drv = '0; d_drv = '0; b_drv = '0; c_drv = '0; e_drv = '0;

    // Reset values while asserted and after release.
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_a_valid", bus_out.a_valid, 1'b0);
    check_eq("rst_d_valid", bus_in.d_valid, 1'b0);
    check_eq("rst_a_ready", bus_in.a_ready, 1'b1);
    check_eq("rst_d_ready", bus_out.d_ready, 1'b1);
`ifdef TL_BUFFER_BCE_EN
    check_eq("rst_b_valid", bus_in.b_valid, 1'b0);
    check_eq("rst_c_valid", bus_out.c_valid, 1'b0);
    check_eq("rst_e_valid", bus_out.e_valid, 1'b0);
    check_eq("rst_bce_ready", {bus_out.b_ready, bus_in.c_ready, bus_in.e_ready}, 3'b111);
`endif
    reset = 1'b1;
    repeat (2) cycle();

    // Single Get beat: visible exactly one cycle after acceptance, for one cycle.
    get_beat = {3'd4, 3'd0, 4'd3, 4'd3, 32'h8000_0040, 8'hff, 64'd0, 1'b0};
    a_drv = get_beat;
    bus_in.a_valid = 1'b1;
    check_eq("get_no_flowthrough", bus_out.a_valid, 1'b0);
    cycle();
    bus_in.a_valid = 1'b0;
    check_eq("get_valid", bus_out.a_valid, 1'b1);
    check_eq("get_bits", a_obs, get_beat);
    cycle();
    check_eq("get_one_cycle", bus_out.a_valid, 1'b0);

    // Backpressure: two beats fill the queue, the third waits.
    base = a_out_cnt;
    bus_out.a_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      a_drv = {3'd4, 3'd0, 4'd3, 4'(k), 32'h1000_0000 + 32'(k), 8'hff, 64'(k), 1'b0};
      bus_in.a_valid = 1'b1;
      if (k == 3) check_eq("a_full_ready", bus_in.a_ready, 1'b0);
      cycle();
    end
    bus_out.a_ready = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 10 && !accepted; n++) begin
      cycle();
      accepted = last_a_enq;
    end
    bus_in.a_valid = 1'b0;
    check_eq("a_third_accepted", accepted, 1'b1);
    repeat (4) cycle();
    check_eq("a_drain_count", a_out_cnt - base, 3);

    // Streaming D with wrap-around: 16 beats, no bubble after the first cycle.
    base = d_out_cnt;
    for (int i = 0; i <= 16; i++) begin
      d_drv = {3'd1, 2'd0, 4'd3, 4'd2, 3'd1, 1'b0, 64'(i), 1'b0};
      bus_out.d_valid = (i < 16);
      cycle();
    end
    bus_out.d_valid = 1'b0;
    check_eq("d_stream_count", d_out_cnt - base, 16);

    // Enqueue and dequeue together at occupancy 1.
    bus_out.a_ready = 1'b0;
    a_drv = {3'd0, 3'd0, 4'd2, 4'd5, 32'h2000_0000, 8'h0f, 64'hAAAA, 1'b0};
    bus_in.a_valid = 1'b1;
    cycle();
    bus_out.a_ready = 1'b1;
    a_drv = {3'd0, 3'd0, 4'd2, 4'd6, 32'h2000_0008, 8'hf0, 64'hBBBB, 1'b0};
    cycle();
    bus_in.a_valid = 1'b0;
    bus_out.a_ready = 1'b0;
    check_eq("occ1_valid", bus_out.a_valid, 1'b1);
    check_eq("occ1_not_full", bus_in.a_ready, 1'b1);
    bus_out.a_ready = 1'b1;
    repeat (2) cycle();

    // Random traffic and ready toggling on both channels.
    for (int n = 0; n < 1000; n++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      a_drv = r[118:0];
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      d_drv = r[81:0];
      bus_in.a_valid  = ($urandom_range(0, 3) != 0);
      bus_out.a_ready = ($urandom_range(0, 2) != 0);
      bus_out.d_valid = ($urandom_range(0, 3) != 0);
      bus_in.d_ready  = ($urandom_range(0, 2) != 0);
      cycle();
    end
    idle();
    repeat (4) cycle();

    // Reset with two D beats queued drops valid immediately.
    bus_in.d_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_drv = {3'd1, 2'd0, 4'd3, 4'(i), 3'd2, 1'b0, 64'h100 + 64'(i), 1'b0};
      bus_out.d_valid = 1'b1;
      cycle();
    end
    bus_out.d_valid = 1'b0;
    check_eq("d_full_before_rst", bus_out.d_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_mid_d_valid", bus_in.d_valid, 1'b0);
    check_eq("rst_mid_d_ready", bus_out.d_ready, 1'b1);
    qa.delete();
    qd.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus_in.d_ready = 1'b1;
    repeat (2) cycle();

    // B/C/E latency.
    b_drv = 38'h2_1234_5678;
    c_drv = {3'd6, 3'd1, 4'd3, 4'd9, 32'hC000_0010, 64'h0123_4567_89AB_CDEF, 1'b0};
    e_drv = 3'd5;
    bus_out.b_valid = 1'b1;
    bus_in.c_valid  = 1'b1;
    bus_in.e_valid  = 1'b1;
`ifdef TL_BUFFER_BCE_EN
    #1;
    check_eq("c_not_same_cycle", bus_out.c_valid, 1'b0);
    @(posedge clock);
    #1;
    bus_out.b_valid = 1'b0;
    bus_in.c_valid  = 1'b0;
    bus_in.e_valid  = 1'b0;
    check_eq("c_valid_next", bus_out.c_valid, 1'b1);
    check_eq("c_bits_next", c_obs, c_drv);
    check_eq("b_valid_next", bus_in.b_valid, 1'b1);
    check_eq("b_bits_next", b_obs, b_drv);
    check_eq("e_valid_next", bus_out.e_valid, 1'b1);
    check_eq("e_bits_next", e_obs, e_drv);
    @(posedge clock);
    #1;
    check_eq("c_valid_drained", bus_out.c_valid, 1'b0);
`else
    bus_out.c_ready = 1'b0;
    bus_in.b_ready  = 1'b0;
    #1;
    check_eq("c_valid_same", bus_out.c_valid, 1'b1);
    check_eq("c_bits_same", c_obs, c_drv);
    check_eq("c_ready_pass", bus_in.c_ready, 1'b0);
    check_eq("b_valid_same", bus_in.b_valid, 1'b1);
    check_eq("b_bits_same", b_obs, b_drv);
    check_eq("b_ready_pass", bus_out.b_ready, 1'b0);
    check_eq("e_valid_same", bus_out.e_valid, 1'b1);
    check_eq("e_bits_same", e_obs, e_drv);
    @(posedge clock);
    #1;
    idle();
    #1;
    check_eq("c_valid_follow", bus_out.c_valid, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
